shru_store_unit: RTL and testbench

- Execute-stage consumer of the shadow-register save request produced by issue/read-operands.
- Takes one context frame (mepc, mcause and saved GPRs) plus a stack base address, then writes the frame word by word to memory through a dedicated dcache store port.
- Signals completion back to issue (`store_valid_o`).
- Flags loads whose page offset aliases a not-yet-written frame word, so the issue side can hold them.

---
 rtl/shru_store_unit_pkg.sv | 32 +++
 rtl/shru_store_unit_offset_cmp.sv | 32 +++
 rtl/shru_store_unit.sv | 142 ++++++++++++++
 tb/tb_shru_store_unit.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shru_store_unit_pkg.sv
// Shared types for the shadow-register save path: FSM states, frame layout and
// small width helpers used by the store unit and its offset comparator.
package shru_store_unit_pkg;

    localparam int unsigned SHRU_XLEN       = 64;
    localparam int unsigned SHRU_NR_WORDS   = 4;
    localparam int unsigned SHRU_MEPC_IDX   = 0;
    localparam int unsigned SHRU_MCAUSE_IDX = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STORE = 2'd1,
        DONE  = 2'd2,
        ERR   = 2'd3
    } shru_state_e;

    // Frame as handed over by issue_read_operands, word k at words[k*XLEN +: XLEN].
    typedef struct packed {
        logic [SHRU_XLEN-1:0]               base;
        logic [SHRU_NR_WORDS*SHRU_XLEN-1:0] words;
    } shru_frame_t;

    // log2 of the word size in bytes.
    function automatic int unsigned shru_word_shift(input int unsigned xlen);
        return (xlen == 64) ? 3 : 2;
    endfunction

    function automatic logic [1:0] shru_size(input int unsigned xlen);
        return (xlen == 64) ? 2'b11 : 2'b10;
    endfunction

endpackage

// File: rtl/shru_store_unit_offset_cmp.sv
// Page-offset alias comparator: flags a load offset that hits any still-pending
// word of a frame, ignoring the byte-within-word bits.
module shru_offset_cmp
    import shru_store_unit_pkg::*;
#(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned NR_WORDS = 4
) (
    input  logic [11:0]         base_offset,
    input  logic [NR_WORDS-1:0] pending,
    input  logic [11:0]         page_offset,
    output logic                match
);

    localparam int unsigned W        = shru_word_shift(XLEN);
    localparam logic [11:0] CMP_MASK = 12'hFFF << W;

    // Offsets wrap inside the 12-bit page, so a frame crossing a page boundary
    // aliases low offsets of the next page as well.
    always_comb begin
        logic [11:0] word_off;
        match    = 1'b0;
        word_off = '0;
        for (int unsigned j = 0; j < NR_WORDS; j++) begin
            word_off = base_offset + 12'(j << W);
            if (pending[j] && (((word_off ^ page_offset) & CMP_MASK) == '0)) begin
                match = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shru_store_unit.sv
// Shadow-register frame store unit: accepts a context frame and writes it word
// by word through a dedicated dcache store port. Optional macro SHRU_ALIGN_CHECK_EN
// rejects misaligned frame bases with an err_o pulse instead of aligning them.
module shru_store_unit
    import shru_store_unit_pkg::*;
#(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned NR_WORDS = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     save_valid_i,
    output logic                     save_ready_o,
    input  logic [XLEN-1:0]          save_addr_i,
    input  logic [NR_WORDS*XLEN-1:0] save_data_i,
    output logic                     store_valid_o,
    output logic                     err_o,
    input  logic [11:0]              page_offset_i,
    output logic                     page_offset_match_o,
    output logic                     req_o,
    input  logic                     gnt_i,
    output logic [XLEN-1:0]          addr_o,
    output logic [XLEN-1:0]          wdata_o,
    output logic [XLEN/8-1:0]        be_o,
    output logic [1:0]               size_o,
    output logic                     we_o
);

    localparam int unsigned     W          = shru_word_shift(XLEN);
    localparam int unsigned     IDX_W      = $clog2(NR_WORDS);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'((XLEN / 8) - 1);

    shru_state_e               state_q, state_d;
    logic [XLEN-1:0]           base_q, base_d;
    logic [NR_WORDS*XLEN-1:0]  words_q, words_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic                      last_word;
    logic [NR_WORDS-1:0]       pending;
    logic [11:0]               cmp_base;
    logic [XLEN-1:0]           cur_word;

`ifdef SHRU_ALIGN_CHECK_EN
    logic misaligned;
    assign misaligned = |(save_addr_i & ~ALIGN_MASK);
`endif

    assign save_ready_o = (state_q == IDLE);
    assign last_word    = (idx_q == IDX_W'(NR_WORDS - 1));

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        words_d = words_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (save_valid_i) begin
                    base_d  = save_addr_i & ALIGN_MASK;
                    words_d = save_data_i;
                    idx_d   = '0;
`ifdef SHRU_ALIGN_CHECK_EN
                    state_d = misaligned ? ERR : STORE;
`else
                    state_d = STORE;
`endif
                end
            end
            STORE: begin
                if (gnt_i) begin
                    if (last_word) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            base_q  <= '0;
            words_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            words_q <= words_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        cur_word = '0;
        for (int unsigned k = 0; k < NR_WORDS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_word = words_q[k*XLEN +: XLEN];
            end
        end
    end

    assign req_o         = (state_q == STORE);
    assign we_o          = req_o;
    assign addr_o        = req_o ? (base_q + (XLEN'(idx_q) << W)) : '0;
    assign wdata_o       = req_o ? cur_word : '0;
    assign be_o          = '1;
    assign size_o        = shru_size(XLEN);
    assign store_valid_o = (state_q == DONE);
`ifdef SHRU_ALIGN_CHECK_EN
    assign err_o         = (state_q == ERR);
`else
    assign err_o         = 1'b0;
`endif

    // Words granted in this cycle still count; they leave the set next cycle.
    always_comb begin
        pending  = '0;
        cmp_base = save_addr_i[11:0];
        if (state_q == STORE) begin
            cmp_base = base_q[11:0];
            for (int unsigned j = 0; j < NR_WORDS; j++) begin
                pending[j] = (IDX_W'(j) >= idx_q);
            end
        end else if ((state_q == IDLE) && save_valid_i) begin
            pending = '1;
        end
    end

    shru_offset_cmp #(
        .XLEN     (XLEN),
        .NR_WORDS (NR_WORDS)
    ) i_offset_cmp (
        .base_offset (cmp_base),
        .pending     (pending),
        .page_offset (page_offset_i),
        .match       (page_offset_match_o)
    );

endmodule

// File: tb/tb_shru_store_unit.sv
// Self-checking bench for shru_store_unit (XLEN=64, NR_WORDS=4): constant vector
// table, hand-written corner sequences and random frames against a frame-level model.
module tb_shru_store_unit;

    localparam int unsigned XLEN = 64;
    localparam int unsigned NRW  = 4;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             save_valid_i;
    logic             save_ready_o;
    logic [63:0]      save_addr_i;
    logic [255:0]     save_data_i;
    logic             store_valid_o;
    logic             err_o;
    logic [11:0]      page_offset_i;
    logic             page_offset_match_o;
    logic             req_o;
    logic             gnt_i;
    logic [63:0]      addr_o;
    logic [63:0]      wdata_o;
    logic [7:0]       be_o;
    logic [1:0]       size_o;
    logic             we_o;

    int checks   = 0;
    int failures = 0;

    shru_store_unit #(
        .XLEN     (XLEN),
        .NR_WORDS (NRW)
    ) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .save_valid_i        (save_valid_i),
        .save_ready_o        (save_ready_o),
        .save_addr_i         (save_addr_i),
        .save_data_i         (save_data_i),
        .store_valid_o       (store_valid_o),
        .err_o               (err_o),
        .page_offset_i       (page_offset_i),
        .page_offset_match_o (page_offset_match_o),
        .req_o               (req_o),
        .gnt_i               (gnt_i),
        .addr_o              (addr_o),
        .wdata_o             (wdata_o),
        .be_o                (be_o),
        .size_o              (size_o),
        .we_o                (we_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    // Any still-pending frame word (index first..3) whose page offset shares bits [11:3].
    function automatic logic model_match(input logic [63:0] b, input int first, input logic [11:0] po);
        logic [63:0] a;
        for (int j = first; j < 4; j++) begin
            a = b + 64'(j * 8);
            if (a[11:3] == po[11:3]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [11:0] pick_po(input logic [63:0] b);
        logic [11:0] lo;
        lo = b[11:0];
        if ($urandom_range(0, 1) == 1)
            return (lo + 12'(8 * $urandom_range(0, 5))) ^ 12'($urandom_range(0, 7));
        return 12'($urandom);
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, save_ready_o, 1);
        chk({tag, "_req"}, req_o, 0);
        chk({tag, "_we"}, we_o, 0);
        chk({tag, "_addr"}, addr_o, 0);
        chk({tag, "_wdata"}, wdata_o, 0);
        chk({tag, "_svalid"}, store_valid_o, 0);
        chk({tag, "_err"}, err_o, 0);
        chk({tag, "_match"}, page_offset_match_o, 0);
        chk({tag, "_be"}, be_o, 8'hFF);
        chk({tag, "_size"}, size_o, 2'b11);
    endtask

    // Drives one frame from its accept cycle to the cycle after completion and
    // checks every cycle; gnt_pat bit c is the grant in the c-th request cycle.
    task automatic run_frame(input logic [63:0] base, input logic [255:0] data,
                             input logic [31:0] gnt_pat, input bit hold, output int cycles);
        logic [63:0] eb;
        logic [11:0] po;
        logic        g;
        int          r;
        int          k;
        eb     = base & ~64'h7;
        cycles = 0;
        save_valid_i  = 1'b1;
        save_addr_i   = base;
        save_data_i   = data;
        gnt_i         = 1'b0;
        po            = pick_po(base);
        page_offset_i = po;
        @(negedge clk_i);
        chk("acc_ready", save_ready_o, 1);
        chk("acc_req", req_o, 0);
        chk("acc_match", page_offset_match_o, model_match(base, 0, po));
        next_cycle();
`ifdef SHRU_ALIGN_CHECK_EN
        if (base[2:0] != 3'b000) begin
            save_valid_i = hold;
            @(negedge clk_i);
            chk("err_pulse", err_o, 1);
            chk("err_req", req_o, 0);
            chk("err_svalid", store_valid_o, 0);
            chk("err_ready", save_ready_o, 0);
            next_cycle();
            if (!hold) begin
                save_valid_i = 1'b0;
                @(negedge clk_i);
                chk("err_after", err_o, 0);
                chk("err_after_ready", save_ready_o, 1);
                next_cycle();
            end
            return;
        end
`endif
        r = 4;
        while (r > 0 && cycles < 40) begin
            gnt_i         = (cycles < 32) ? gnt_pat[cycles] : 1'b1;
            save_valid_i  = hold;
            po            = pick_po(eb);
            page_offset_i = po;
            k             = 4 - r;
            @(negedge clk_i);
            chk("st_req", req_o, 1);
            chk("st_we", we_o, 1);
            chk("st_addr", addr_o, eb + 64'(8 * k));
            chk("st_wdata", wdata_o, data[k*64 +: 64]);
            chk("st_ready", save_ready_o, 0);
            chk("st_svalid", store_valid_o, 0);
            chk("st_err", err_o, 0);
            chk("st_match", page_offset_match_o, model_match(eb, k, po));
            g = gnt_i;
            next_cycle();
            if (g) r--;
            cycles++;
        end
        gnt_i         = 1'b0;
        page_offset_i = pick_po(eb);
        @(negedge clk_i);
        chk("done_svalid", store_valid_o, 1);
        chk("done_req", req_o, 0);
        chk("done_ready", save_ready_o, 0);
        chk("done_match", page_offset_match_o, 0);
        next_cycle();
        if (!hold) begin
            save_valid_i = 1'b0;
            @(negedge clk_i);
            chk("idle_ready", save_ready_o, 1);
            chk("idle_svalid", store_valid_o, 0);
            chk("idle_req", req_o, 0);
            next_cycle();
        end
    endtask

    typedef struct {
        logic [63:0] base;
        logic        valid;
        logic [11:0] po;
        logic        exp;
    } vec_t;

    initial begin
        vec_t         tab [9];
        logic [255:0] frame_a;
        logic [255:0] frame_b;
        int           cyc;

        tab[0] = '{64'h1FF0, 1'b1, 12'hFF0, 1'b1};
        tab[1] = '{64'h1FF0, 1'b1, 12'hFF8, 1'b1};
        tab[2] = '{64'h1FF0, 1'b1, 12'h000, 1'b1};
        tab[3] = '{64'h1FF0, 1'b1, 12'h00C, 1'b1};
        tab[4] = '{64'h1FF0, 1'b1, 12'h010, 1'b0};
        tab[5] = '{64'h1FF0, 1'b1, 12'hFE8, 1'b0};
        tab[6] = '{64'h1FF0, 1'b0, 12'hFF0, 1'b0};
        tab[7] = '{64'h3_0000_0100, 1'b1, 12'h118, 1'b1};
        tab[8] = '{64'h3_0000_0100, 1'b1, 12'h120, 1'b0};

        frame_a = {64'hA3A3_A3A3_0000_0003, 64'hA2A2_A2A2_0000_0002,
                   64'hA1A1_A1A1_0000_0001, 64'hA0A0_A0A0_0000_0000};
        frame_b = {64'hB3B3_0000_1111_0003, 64'hB2B2_0000_1111_0002,
                   64'hB1B1_0000_1111_0001, 64'hB0B0_0000_1111_0000};

        rst_ni        = 1'b0;
        save_valid_i  = 1'b0;
        save_addr_i   = '0;
        save_data_i   = '0;
        page_offset_i = '0;
        gnt_i         = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check_reset_outputs("rst");
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        next_cycle();

        // IDLE-side alias table; valid drops before the edge so nothing is accepted.
        for (int i = 0; i < 9; i++) begin
            save_valid_i  = tab[i].valid;
            save_addr_i   = tab[i].base;
            page_offset_i = tab[i].po;
            @(negedge clk_i);
            chk("tab_match", page_offset_match_o, tab[i].exp);
            save_valid_i = 1'b0;
            next_cycle();
            chk("tab_noaccept", save_ready_o, 1);
        end

        run_frame(64'h8000_0FE0, frame_a, 32'hFFFF_FFFF, 1'b0, cyc);
        chk("basic_latency", cyc, 4);

        run_frame(64'h8000_0FE0, frame_a, 32'hFFFF_FFE3, 1'b0, cyc);
        chk("stall_latency", cyc, 7);

        // Offset hazard against base 0x1FF0.
        save_valid_i  = 1'b1;
        save_addr_i   = 64'h1FF0;
        save_data_i   = frame_b;
        page_offset_i = 12'hFF8;
        @(negedge clk_i);
        chk("hz_idle", page_offset_match_o, 1);
        next_cycle();
        save_valid_i = 1'b0;
        gnt_i        = 1'b0;
        @(negedge clk_i);
        chk("hz_w0_pending", page_offset_match_o, 1);
        next_cycle();
        gnt_i         = 1'b1;
        page_offset_i = 12'hFF0;
        @(negedge clk_i);
        chk("hz_grant_same_cycle", page_offset_match_o, 1);
        next_cycle();
        @(negedge clk_i);
        chk("hz_w0_gone", page_offset_match_o, 0);
        next_cycle();
        gnt_i = 1'b0;
        @(negedge clk_i);
        chk("hz_ff0_after", page_offset_match_o, 0);
        chk("hz_addr2", addr_o, 64'h2000);
        page_offset_i = 12'h008;
        #1;
        chk("hz_wrap", page_offset_match_o, 1);
        next_cycle();
        gnt_i = 1'b1;
        next_cycle();
        next_cycle();
        gnt_i = 1'b0;
        @(negedge clk_i);
        chk("hz_done", store_valid_o, 1);
        chk("hz_done_match", page_offset_match_o, 0);
        next_cycle();

        // Reset after the second grant.
        save_valid_i  = 1'b1;
        save_addr_i   = 64'h4000;
        save_data_i   = frame_a;
        page_offset_i = 12'h000;
        next_cycle();
        save_valid_i = 1'b0;
        gnt_i        = 1'b1;
        next_cycle();
        next_cycle();
        gnt_i = 1'b0;
        @(negedge clk_i);
        chk("mid_addr", addr_o, 64'h4010);
        page_offset_i = 12'h7F0;
        #1 rst_ni = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("mid_no_svalid", store_valid_o, 0);
            chk("mid_no_req", req_o, 0);
            next_cycle();
        end
        run_frame(64'h4000, frame_b, 32'hFFFF_FFFF, 1'b0, cyc);
        chk("mid_next_latency", cyc, 4);

        // Back-pressure: valid stays high, second accept right after completion.
        run_frame(64'h5000, frame_a, 32'hFFFF_FFFF, 1'b1, cyc);
        run_frame(64'h5000, frame_a, 32'h0000_FFFF, 1'b0, cyc);
        chk("bp_second_latency", cyc, 4);

        // Misaligned base: stores aligned down by default, rejected with the check enabled.
        run_frame(64'h1004, frame_b, 32'hFFFF_FFFF, 1'b0, cyc);

        for (int n = 0; n < 30; n++) begin
            logic [63:0]  b;
            logic [255:0] d;
            b = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) b[2:0] = 3'b000;
            d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            run_frame(b, d, $urandom, 1'($urandom_range(0, 1)), cyc);
        end
        save_valid_i = 1'b0;
        next_cycle();
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
